// File: rtl/reg_write_arbiter.sv
// Two-requester round-robin write-port arbiter with locked multi-beat ownership,
// driving a single registered write port into a 32x32 register bank.
module reg_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_lock,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_lock,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                grant0, grant1;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  // Grant/next-state logic; ready is gated by reset so nothing transfers while held.
  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        grant0 = req0_valid && (!req1_valid || last_q);
        grant1 = req1_valid && (!req0_valid || !last_q);
      end
      OWN0:    grant0 = req0_valid;
      OWN1:    grant1 = req1_valid;
      default: state_d = IDLE;
    endcase
    if (!reset) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
    if (grant0) begin
      state_d = req0_lock ? OWN0 : IDLE;
      last_d  = 1'b0;
    end else if (grant1) begin
      state_d = req1_lock ? OWN1 : IDLE;
      last_d  = 1'b1;
    end
  end

  // Write port: register 0 is hardwired zero, so its beats update addr/data but not enable.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (grant0) begin
      wr_en_d   = (req0_addr != '0);
      wr_addr_d = req0_addr;
      wr_data_d = req0_data;
    end else if (grant1) begin
      wr_en_d   = (req1_addr != '0);
      wr_addr_d = req1_addr;
      wr_data_d = req1_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign owner      = state_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a behavioural arbiter model predicts
// grants and the registered write port, plus directed checks of key sequences.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_lock, req0_ready;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid, req1_lock, req1_ready;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  owner;

  reg_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_lock(req0_lock), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_lock(req1_lock), .req1_ready(req1_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic        en;
    logic [4:0]  a;
    logic [31:0] d;
    logic [1:0]  own;
  } exp_t;

  beat_t q0[$];
  beat_t q1[$];
  exp_t  sb[$];
  int    glog[$];

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state
  logic [1:0]  m_state;
  logic        m_last;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 2'b00;
    m_last  = 1'b1;
    m_addr  = '0;
    m_data  = '0;
  endtask

  task automatic drive();
    req0_valid = (q0.size() != 0);
    req1_valid = (q1.size() != 0);
    if (q0.size() != 0) begin
      req0_addr = q0[0].a; req0_data = q0[0].d; req0_lock = q0[0].l;
    end
    if (q1.size() != 0) begin
      req1_addr = q1[0].a; req1_data = q1[0].d; req1_lock = q1[0].l;
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle();
    logic  v0, v1, g0, g1;
    exp_t  e;
    drive();
    #1;
    v0 = req0_valid;
    v1 = req1_valid;
    g0 = 1'b0;
    g1 = 1'b0;
    case (m_state)
      2'b00: begin
        g0 = v0 && (!v1 || m_last);
        g1 = v1 && (!v0 || !m_last);
      end
      2'b01: g0 = v0;
      default: g1 = v1;
    endcase
    check("req0_ready", req0_ready, g0);
    check("req1_ready", req1_ready, g1);
    glog.push_back(req0_ready ? 0 : (req1_ready ? 1 : -1));
    e.en = 1'b0;
    if (g0) begin
      e.en = (q0[0].a != 0); m_addr = q0[0].a; m_data = q0[0].d;
      m_state = q0[0].l ? 2'b01 : 2'b00; m_last = 1'b0;
      void'(q0.pop_front());
    end else if (g1) begin
      e.en = (q1[0].a != 0); m_addr = q1[0].a; m_data = q1[0].d;
      m_state = q1[0].l ? 2'b10 : 2'b00; m_last = 1'b1;
      void'(q1.pop_front());
    end
    e.a = m_addr;
    e.d = m_data;
    e.own = m_state;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("wr_en", wr_en, e.en);
      check("wr_addr", wr_addr, e.a);
      check("wr_data", wr_data, e.d);
      check("owner", owner, e.own);
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      check("drain_timeout", 1, 0);
      q0.delete();
      q1.delete();
    end
  endtask

  initial begin
    reset = 1'b0;
    req0_valid = 0; req0_addr = 0; req0_data = 0; req0_lock = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0; req1_lock = 0;
    model_reset();

    // Reset state, with beats presented that must not transfer
    q0.push_back('{a: 5'd3, d: 32'h3, l: 1'b0});
    q1.push_back('{a: 5'd4, d: 32'h4, l: 1'b0});
    drive();
    repeat (2) @(negedge clk);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_owner", owner, 0);
    q0.delete();
    q1.delete();
    reset = 1'b1;

    // Tie round-robin
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{a: 5'd1, d: 32'h11, l: 1'b0});
      q1.push_back('{a: 5'd2, d: 32'h22, l: 1'b0});
    end
    glog.delete();
    drain(20);
    for (int i = 0; i < 8; i++) check("tie_grant", glog[i], i % 2);

    // Single requester
    q0.push_back('{a: 5'd5, d: 32'hDEADBEEF, l: 1'b0});
    cycle();
    check("single_en", wr_en, 1);
    check("single_addr", wr_addr, 5);
    check("single_data", wr_data, 32'hDEADBEEF);
    cycle();
    check("single_en_after", wr_en, 0);

    // Write to r0: accepted but no enable
    q0.push_back('{a: 5'd0, d: 32'hFFFFFFFF, l: 1'b0});
    glog.delete();
    cycle();
    check("r0_ready", glog[0], 0);
    check("r0_en", wr_en, 0);
    check("r0_data", wr_data, 32'hFFFFFFFF);

    // Lock burst from req1 while req0 waits; req1 wins the tie after the r0 write
    q1.push_back('{a: 5'd8,  d: 32'hA, l: 1'b1});
    q1.push_back('{a: 5'd9,  d: 32'hB, l: 1'b1});
    q1.push_back('{a: 5'd10, d: 32'hC, l: 1'b0});
    q0.push_back('{a: 5'd3,  d: 32'h33, l: 1'b0});
    glog.delete();
    drain(20);
    for (int i = 0; i < 4; i++) check("lock_grant", glog[i], (i < 3) ? 1 : 0);
    check("lock_owner_end", owner, 0);

    // Owner stall: req0 locks then goes quiet, req1 must wait
    q0.push_back('{a: 5'd4, d: 32'h44, l: 1'b1});
    cycle();
    check("stall_owner_set", owner, 2'b01);
    q1.push_back('{a: 5'd6, d: 32'h66, l: 1'b0});
    glog.delete();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_grant", glog[i], -1);
      check("stall_owner", owner, 2'b01);
    end
    q0.push_back('{a: 5'd7, d: 32'h77, l: 1'b0});
    drain(10);
    cycle();

    // Random traffic; each stream ends unlocked so it always drains
    for (int i = 0; i < 60; i++) begin
      q0.push_back('{a: 5'($urandom_range(0, 31)), d: $urandom, l: 1'($urandom_range(0, 1))});
      q1.push_back('{a: 5'($urandom_range(0, 31)), d: $urandom, l: 1'($urandom_range(0, 1))});
    end
    q0.push_back('{a: 5'd1, d: 32'h1, l: 1'b0});
    q1.push_back('{a: 5'd2, d: 32'h2, l: 1'b0});
    drain(400);
    cycle();

    // Async reset mid-burst in OWN1
    q1.push_back('{a: 5'd8, d: 32'hA, l: 1'b1});
    q1.push_back('{a: 5'd9, d: 32'hB, l: 1'b1});
    cycle();
    check("ar_owner_set", owner, 2'b10);
    check("ar_en_set", wr_en, 1);
    #2;
    reset = 1'b0;
    drive();
    #1;
    check("ar_wr_en", wr_en, 0);
    check("ar_wr_addr", wr_addr, 0);
    check("ar_wr_data", wr_data, 0);
    check("ar_owner", owner, 0);
    check("ar_ready1", req1_ready, 0);
    model_reset();
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    q0.push_back('{a: 5'd12, d: 32'hC0, l: 1'b0});
    q1.push_back('{a: 5'd10, d: 32'hC, l: 1'b0});
    glog.delete();
    drain(20);
    check("ar_first_grant", glog[0], 0);
    cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Two-requester write-port arbiter and sequencer for the 32-entry x 32-bit register bank built from the team's 32-bit register blocks. It accepts write beats from two independent producers (requester 0: ALU writeback, requester 1: load/memory return) over a valid/ready handshake. It grants them round-robin, supports locked multi-beat ownership, and drives a single registered write port (enable, address, data) into the bank.

## Interface
- DATA_W, 32, width of write data
- ADDR_W, 5, width of register address
- clk  in  1  rising-edge clock for all state
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- req0_valid  in  1  requester 0 has a write beat
- req0_addr  in  ADDR_W  requester 0 destination register
- req0_data  in  DATA_W  requester 0 write data
- req0_lock  in  1  requester 0 keeps ownership after this beat
- req0_ready  out  1  requester 0 beat accepted this cycle
- req1_valid / req1_addr / req1_data / req1_lock / req1_ready: same as requester 0, for requester 1
- wr_en  out  1  register bank write enable
- wr_addr  out  ADDR_W  register bank write address
- wr_data  out  DATA_W  register bank write data
- owner  out  2  FSM state: 00 IDLE, 01 OWN0, 10 OWN1

## Operation
- Transfer: a beat moves when reqN_valid && reqN_ready in the same cycle. A requester holds valid, addr, data and lock stable until ready.
- At most one ready is high per cycle. Ready never depends on the requester's own ready, so there is no combinational loop.
- FSM states:
  - IDLE: grant goes to the single valid requester. If both are valid, grant goes to the requester not served last (last_ptr).
  - OWN0: only requester 0 can be granted. req1_ready is held 0.
  - OWN1: mirror of OWN0 for requester 1.
- Transitions:
  - IDLE -> OWNn when a beat from n transfers with lock=1.
  - OWNn -> IDLE when a beat from n transfers with lock=0.
  - OWNn holds indefinitely while reqn_valid=0 (no timeout). Other requesters stall.
- last_ptr updates to the granted index on every transfer, including beats inside OWNn.
- Register 0 is hardwired zero:
  - A beat addressed to 0 is accepted (ready=1) and updates FSM and last_ptr.
  - It produces wr_en=0 on the next cycle. wr_addr and wr_data still update.
- No transfer in a cycle: wr_en=0 next cycle. wr_addr and wr_data hold their previous values.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, owner=00 (IDLE), last_ptr=1 (requester 0 wins first tie), req0_ready=0, req1_ready=0.

## Timing
- Write latency 1: a beat transferring at edge k appears on wr_en/wr_addr/wr_data after edge k. The bank captures it at edge k+1.
- Throughput: one beat per cycle, sustained, with no bubble between grants or on ownership handoff.
- readyN is combinational from reqN_valid, the other requester's valid, owner and last_ptr. All outputs except ready are registered.
- Simultaneous events:
  - In IDLE with both valid, exactly one is granted.
  - A lock=0 beat that ends OWNn makes IDLE arbitration available the next cycle, not the same cycle.
- Reset mid-operation: assertion clears all outputs asynchronously, and any lock is dropped.
  - A beat presented during reset is not transferred (both ready = 0).
  - After deassertion, the first edge arbitrates from IDLE with requester 0 as tie-winner.

## Test plan
- Single requester: req0 writes addr 5 data 0xDEADBEEF -> req0_ready=1 the same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; the cycle after, wr_en=0.
- Tie round-robin: both valid continuously, req0 (addr 1, 0x11) and req1 (addr 2, 0x22) -> grants alternate 0,1,0,1; wr_addr sequence is 1,2,1,2 with wr_en=1 every cycle.
- Lock burst: req1 sends lock=1 (addr 8, 0xA), lock=1 (addr 9, 0xB), lock=0 (addr 10, 0xC) while req0 is valid throughout:
  - owner=10 for the burst and req0_ready=0 for three cycles.
  - req0 is granted on the 4th cycle; owner returns to 00.
- Write to r0: req0 addr 0 data 0xFFFFFFFF -> req0_ready=1; next cycle wr_en=0, wr_data=0xFFFFFFFF; last_ptr=0, so req1 wins the following tie.
- Owner stall: in OWN0 with req0_valid=0 for 5 cycles and req1_valid=1 -> req1_ready=0 and wr_en=0 throughout; owner stays 01.
- Async reset mid-burst: assert reset=0 between edges while in OWN1 with wr_en=1 -> wr_en, wr_addr, wr_data and owner go to 0 before the next edge; after release, a req0/req1 tie grants req0 first.
